// File: rtl/mips_exec_alu.sv
// EX-stage 32-bit integer ALU with one-cycle-early operation pre-decode.
// The operation select is registered from the ID fields; the result is registered into MM.
module mips_exec_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode_fwd,
   input  logic [5:0]  funct_fwd,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [31:0] rrs,
   input  logic [31:0] rrt_in,
   input  logic [15:0] imm,
   input  logic [4:0]  shamt_in,
   output logic [31:0] rslt
);

   localparam int unsigned W      = 32;
   localparam int unsigned SH_W   = 5;
   localparam int unsigned NOPS   = 12;
   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_SUB  = 1;
   localparam int unsigned OP_AND  = 2;
   localparam int unsigned OP_OR   = 3;
   localparam int unsigned OP_XOR  = 4;
   localparam int unsigned OP_NOR  = 5;
   localparam int unsigned OP_SLT  = 6;
   localparam int unsigned OP_SLTU = 7;
   localparam int unsigned OP_SLL  = 8;
   localparam int unsigned OP_SRL  = 9;
   localparam int unsigned OP_SRA  = 10;
   localparam int unsigned OP_LUI  = 11;

   logic [NOPS-1:0] sel_d;
   logic [NOPS-1:0] sel;
   logic [W-1:0]    imm_sext;
   logic [W-1:0]    imm_zext;
   logic [W-1:0]    opb;
   logic [SH_W-1:0] shift;
   logic            is_r;
   logic            use_zext;
   logic            var_shift;
   logic [W-1:0]    result_c;

   // One-hot decode of the instruction entering EX next cycle; all-zero means result 0
   always_comb begin
      sel_d = '0;
      if (opcode_fwd == 6'h00) begin
         case (funct_fwd)
            6'h20, 6'h21: sel_d[OP_ADD]  = 1'b1;
            6'h22, 6'h23: sel_d[OP_SUB]  = 1'b1;
            6'h24:        sel_d[OP_AND]  = 1'b1;
            6'h25:        sel_d[OP_OR]   = 1'b1;
            6'h26:        sel_d[OP_XOR]  = 1'b1;
            6'h27:        sel_d[OP_NOR]  = 1'b1;
            6'h2A:        sel_d[OP_SLT]  = 1'b1;
            6'h2B:        sel_d[OP_SLTU] = 1'b1;
            6'h00, 6'h04: sel_d[OP_SLL]  = 1'b1;
            6'h02, 6'h06: sel_d[OP_SRL]  = 1'b1;
            6'h03, 6'h07: sel_d[OP_SRA]  = 1'b1;
            default:      sel_d = '0;
         endcase
      end else begin
         case (opcode_fwd)
            6'h08, 6'h09, 6'h23, 6'h2B: sel_d[OP_ADD] = 1'b1;
            6'h0A:   sel_d[OP_SLT]  = 1'b1;
            6'h0B:   sel_d[OP_SLTU] = 1'b1;
            6'h0C:   sel_d[OP_AND]  = 1'b1;
            6'h0D:   sel_d[OP_OR]   = 1'b1;
            6'h0E:   sel_d[OP_XOR]  = 1'b1;
            6'h0F:   sel_d[OP_LUI]  = 1'b1;
            default: sel_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sel <= '0;
      else     sel <= sel_d;
   end

   // Operand selection only: pick rt vs extended immediate and fixed vs variable shift
   always_comb begin
      imm_sext  = {{16{imm[15]}}, imm};
      imm_zext  = {16'h0000, imm};
      is_r      = (opcode == 6'h00);
      use_zext  = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
      var_shift = is_r && ((funct == 6'h04) || (funct == 6'h06) || (funct == 6'h07));
      opb       = is_r ? rrt_in : (use_zext ? imm_zext : imm_sext);
      shift     = var_shift ? rrs[SH_W-1:0] : shamt_in;
   end

   always_comb begin
      result_c = '0;
      if (sel[OP_ADD])       result_c = rrs + opb;
      else if (sel[OP_SUB])  result_c = rrs - opb;
      else if (sel[OP_AND])  result_c = rrs & opb;
      else if (sel[OP_OR])   result_c = rrs | opb;
      else if (sel[OP_XOR])  result_c = rrs ^ opb;
      else if (sel[OP_NOR])  result_c = ~(rrs | opb);
      else if (sel[OP_SLT])  result_c = W'($signed(rrs) < $signed(opb));
      else if (sel[OP_SLTU]) result_c = W'(rrs < opb);
      else if (sel[OP_SLL])  result_c = rrt_in << shift;
      else if (sel[OP_SRL])  result_c = rrt_in >> shift;
      else if (sel[OP_SRA])  result_c = $unsigned($signed(rrt_in) >>> shift);
      else if (sel[OP_LUI])  result_c = {imm, 16'h0000};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rslt <= '0;
      else     rslt <= result_c;
   end

endmodule

// File: tb/tb_mips_exec_alu.sv
// Directed bench for mips_exec_alu: reset, pipelined back-to-back ops, immediates, compares, shifts.
module tb_mips_exec_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode_fwd, funct_fwd, opcode, funct;
   logic [31:0] rrs, rrt_in;
   logic [15:0] imm;
   logic [4:0]  shamt_in;
   logic [31:0] rslt;

   int checks   = 0;
   int failures = 0;

   mips_exec_alu dut (
      .clk(clk), .rst(rst),
      .opcode_fwd(opcode_fwd), .funct_fwd(funct_fwd),
      .opcode(opcode), .funct(funct),
      .rrs(rrs), .rrt_in(rrt_in), .imm(imm), .shamt_in(shamt_in),
      .rslt(rslt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Decode cycle, then execute cycle with operands, then sample one cycle after operands
   task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                         input logic [4:0] sh, input logic [31:0] exp);
      @(negedge clk);
      opcode = 6'h3F; funct = 6'h00;
      opcode_fwd = op; funct_fwd = fn;
      @(negedge clk);
      opcode = op; funct = fn;
      rrs = rs; rrt_in = rt; imm = im; shamt_in = sh;
      opcode_fwd = 6'h3F; funct_fwd = 6'h00;
      @(posedge clk);
      #1 check(tag, rslt, exp);
   endtask

   initial begin
      rst = 1'b1;
      opcode_fwd = 6'h3F; funct_fwd = 6'h00;
      opcode = 6'h3F; funct = 6'h00;
      rrs = '0; rrt_in = '0; imm = '0; shamt_in = '0;
      #1 check("reset_init", rslt, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Async reset mid-cycle with a nonzero result held
      run_op("ori_1234", 6'h0D, 6'h00, 32'h0, 32'h0, 16'h1234, 5'd0, 32'h00001234);
      #2 rst = 1'b1;
      #1 check("async_rst", rslt, 32'h0);
      opcode_fwd = 6'h00; funct_fwd = 6'h21;
      @(posedge clk);
      #1 check("rst_hold", rslt, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_op("addu_after_rst", 6'h00, 6'h21, 32'h3, 32'h4, 16'h0, 5'd0, 32'h7);

      // Back-to-back addu then subu
      @(negedge clk);
      opcode = 6'h3F; funct = 6'h00;
      opcode_fwd = 6'h00; funct_fwd = 6'h21;
      @(negedge clk);
      opcode = 6'h00; funct = 6'h21; rrs = 32'hFFFFFFFF; rrt_in = 32'h1;
      opcode_fwd = 6'h00; funct_fwd = 6'h23;
      @(posedge clk);
      #1 check("pipe_addu", rslt, 32'h0);
      @(negedge clk);
      opcode = 6'h00; funct = 6'h23; rrs = 32'h5; rrt_in = 32'h7;
      opcode_fwd = 6'h3F; funct_fwd = 6'h00;
      @(posedge clk);
      #1 check("pipe_subu", rslt, 32'hFFFFFFFE);

      // Immediates
      run_op("addiu",  6'h09, 6'h00, 32'h10,       32'h0, 16'hFFFF, 5'd0, 32'h0000000F);
      run_op("addi",   6'h08, 6'h00, 32'h0,        32'h0, 16'hFFFF, 5'd0, 32'hFFFFFFFF);
      run_op("ori",    6'h0D, 6'h00, 32'h0,        32'h0, 16'hFFFF, 5'd0, 32'h0000FFFF);
      run_op("andi",   6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8001, 5'd0, 32'h00008001);
      run_op("xori",   6'h0E, 6'h00, 32'h0000FFFF, 32'h0, 16'h00FF, 5'd0, 32'h0000FF00);
      run_op("lui",    6'h0F, 6'h00, 32'h12345678, 32'h0, 16'hABCD, 5'd0, 32'hABCD0000);
      run_op("lw",     6'h23, 6'h00, 32'h100,      32'h0, 16'hFFFC, 5'd0, 32'h000000FC);
      run_op("sw",     6'h2B, 6'h00, 32'h200,      32'h0, 16'h0010, 5'd0, 32'h00000210);

      // R-format arithmetic/logic
      run_op("add_wrap", 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1,        16'h0, 5'd0, 32'h80000000);
      run_op("sub",      6'h00, 6'h22, 32'h0,        32'h1,        16'h0, 5'd0, 32'hFFFFFFFF);
      run_op("and",      6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'hF000F000);
      run_op("or",       6'h00, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'hFFF0FFF0);
      run_op("xor",      6'h00, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'h0FF00FF0);
      run_op("nor",      6'h00, 6'h27, 32'h0,        32'h0,        16'h0, 5'd0, 32'hFFFFFFFF);

      // Compares
      run_op("slt",   6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0,    5'd0, 32'h1);
      run_op("sltu",  6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1, 16'h0,    5'd0, 32'h0);
      run_op("slti",  6'h0A, 6'h00, 32'h0,        32'h0, 16'h8000, 5'd0, 32'h0);
      run_op("sltiu", 6'h0B, 6'h00, 32'h0,        32'h0, 16'h8000, 5'd0, 32'h1);

      // Shifts
      run_op("sll4",   6'h00, 6'h00, 32'h0,  32'h80000001, 16'h0, 5'd4, 32'h00000010);
      run_op("srl4",   6'h00, 6'h02, 32'h0,  32'h80000001, 16'h0, 5'd4, 32'h08000000);
      run_op("sra4",   6'h00, 6'h03, 32'h0,  32'h80000001, 16'h0, 5'd4, 32'hF8000000);
      run_op("srav33", 6'h00, 6'h07, 32'd33, 32'h80000001, 16'h0, 5'd4, 32'hC0000000);
      run_op("sllv33", 6'h00, 6'h04, 32'd33, 32'h80000001, 16'h0, 5'd4, 32'h00000002);
      run_op("srlv0",  6'h00, 6'h06, 32'd32, 32'h80000001, 16'h0, 5'd4, 32'h80000001);
      run_op("sll0",   6'h00, 6'h00, 32'h0,  32'h80000001, 16'h0, 5'd0, 32'h80000001);

      // Non-ALU ops produce 0
      run_op("beq",   6'h04, 6'h00, 32'h5,    32'h5,    16'h0004, 5'd3, 32'h0);
      run_op("j",     6'h02, 6'h2A, 32'h1234, 32'h5678, 16'h1111, 5'd3, 32'h0);
      run_op("undef", 6'h3F, 6'h20, 32'h1234, 32'h5678, 16'h1111, 5'd3, 32'h0);
      run_op("jr",    6'h00, 6'h08, 32'h1234, 32'h5678, 16'h1111, 5'd3, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
